// File: rtl/program_flash_if.sv
// Fetch and data-side bus of the self-programmable program store.
// The master is the core/SFR side and the slave is the flash block.
interface program_flash_if #(
  parameter int ADDR_WIDTH  = 13,
  parameter int INSTR_WIDTH = 14
);
  // fetch port
  logic                   rd_en;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   stall;

  // data-side port (EEADR/EEDATA/EECON)
  logic [ADDR_WIDTH-1:0]  pm_addr;
  logic [INSTR_WIDTH-1:0] pm_wdata;
  logic                   pm_rd_req;
  logic [INSTR_WIDTH-1:0] pm_rdata;
  logic                   unlock_en;
  logic [7:0]             unlock_data;
  logic                   pm_wr_req;
  logic                   busy;
  logic                   done;
  logic                   wr_err;
  logic                   err_clr;

  modport master (
    output rd_en, addr, pm_addr, pm_wdata, pm_rd_req,
           unlock_en, unlock_data, pm_wr_req, err_clr,
    input  instr, stall, pm_rdata, busy, done, wr_err
  );

  modport slave (
    input  rd_en, addr, pm_addr, pm_wdata, pm_rd_req,
           unlock_en, unlock_data, pm_wr_req, err_clr,
    output instr, stall, pm_rdata, busy, done, wr_err
  );
endinterface

// File: rtl/program_flash.sv
// Program memory with registered fetch/data reads and an unlock-gated,
// timed single-word self-write that stalls fetch while it runs.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | waiting for 0x55 on the unlock strobe
//   ST_UNLOCK1 | 0x55 seen, waiting for 0xAA within the window
//   ST_ARMED   | unlocked, waiting for pm_wr_req within the window
//   ST_WRITE   | timed write in progress, fetch and data port stalled
module program_flash #(
  parameter int ADDR_WIDTH    = 13,
  parameter int INSTR_WIDTH   = 14,
  parameter int WRITE_CYCLES  = 16,
  parameter int UNLOCK_WINDOW = 4
) (
  input  logic clk,
  input  logic rst,
  program_flash_if.slave bus
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int WIN_W  = $clog2(UNLOCK_WINDOW + 1);
  localparam int WCNT_W = $clog2(WRITE_CYCLES);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(UNLOCK_WINDOW - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UNLOCK1,
    ST_ARMED,
    ST_WRITE
  } state_e;

  state_e                 state_q, state_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                   wr_err_q, wr_err_d;
  logic [INSTR_WIDTH-1:0] instr_q, pm_rdata_q;
  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  logic busy;
  logic commit;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      wcnt_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      wcnt_q    <= wcnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    wcnt_d    = wcnt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_err_d  = wr_err_q;

    if (bus.err_clr) begin
      wr_err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.pm_wr_req) begin
          wr_err_d = 1'b1;
        end
        if (bus.unlock_en && bus.unlock_data == 8'h55) begin
          state_d = ST_UNLOCK1;
          win_d   = '0;
        end
      end

      ST_UNLOCK1: begin
        if (bus.pm_wr_req) begin
          wr_err_d = 1'b1;
        end
        if (bus.unlock_en) begin
          win_d = '0;
          if (bus.unlock_data == 8'hAA) begin
            state_d = ST_ARMED;
          end else if (bus.unlock_data != 8'h55) begin
            state_d = ST_IDLE;
          end
        end else if (win_q == WIN_LAST) begin
          state_d = ST_IDLE;
          win_d   = '0;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end

      ST_ARMED: begin
        // a write request takes priority over a coincident unlock strobe
        if (bus.pm_wr_req) begin
          state_d   = ST_WRITE;
          win_d     = '0;
          wcnt_d    = '0;
          wr_addr_d = bus.pm_addr;
          wr_data_d = bus.pm_wdata;
        end else if (bus.unlock_en) begin
          state_d = ST_IDLE;
          win_d   = '0;
        end else if (win_q == WIN_LAST) begin
          state_d = ST_IDLE;
          win_d   = '0;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end

      ST_WRITE: begin
        if (wcnt_q == WCNT_LAST) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        win_d   = '0;
        wcnt_d  = '0;
      end
    endcase
  end

  // outputs
  always_comb begin
    busy   = 1'b0;
    commit = 1'b0;
    if (state_q == ST_WRITE) begin
      busy   = 1'b1;
      commit = (wcnt_q == WCNT_LAST);
    end
  end

  // read ports freeze while a write is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= '0;
      pm_rdata_q <= '0;
    end else begin
      if (bus.rd_en && !busy) begin
        instr_q <= mem_q[bus.addr];
      end
      if (bus.pm_rd_req && !busy) begin
        pm_rdata_q <= mem_q[bus.pm_addr];
      end
    end
  end

  // array is not reset; a reset on the commit edge aborts the write
  always_ff @(posedge clk) begin
    if (!rst && commit) begin
      mem_q[wr_addr_q] <= wr_data_q;
    end
  end

  assign bus.instr    = instr_q;
  assign bus.pm_rdata = pm_rdata_q;
  assign bus.stall    = busy;
  assign bus.busy     = busy;
  assign bus.done     = commit;
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_program_flash.sv
// Directed self-checking bench for program_flash: reset, unlock/write,
// window boundaries, stall behaviour and reset abort.
module tb_program_flash;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   busy_cycles;
  int   done_cnt;
  int   done_idx;
  int   instr_moved;
  int   rdata_moved;
  int   err_seen;

  program_flash_if #(.ADDR_WIDTH(13), .INSTR_WIDTH(14)) bus ();

  program_flash #(
    .ADDR_WIDTH(13),
    .INSTR_WIDTH(14),
    .WRITE_CYCLES(16),
    .UNLOCK_WINDOW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic unlock(input logic [7:0] val);
    bus.unlock_en   = 1'b1;
    bus.unlock_data = val;
    step();
    bus.unlock_en   = 1'b0;
    bus.unlock_data = 8'h00;
  endtask

  task automatic wr_req(input logic [12:0] a, input logic [13:0] d);
    bus.pm_addr   = a;
    bus.pm_wdata  = d;
    bus.pm_wr_req = 1'b1;
    step();
    bus.pm_wr_req = 1'b0;
  endtask

  task automatic seq(input logic [7:0] second, input int gap1, input int gap2,
                     input logic [12:0] a, input logic [13:0] d);
    unlock(8'h55);
    repeat (gap1) step();
    unlock(second);
    repeat (gap2) step();
    wr_req(a, d);
  endtask

  // measures the busy interval starting at the current sample point
  task automatic wait_write();
    busy_cycles = 0;
    done_cnt    = 0;
    done_idx    = -1;
    for (int i = 0; i < 40 && bus.busy === 1'b1; i++) begin
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_idx = i;
      end
      busy_cycles++;
      step();
    end
  endtask

  task automatic read_both(input logic [12:0] a);
    bus.rd_en     = 1'b1;
    bus.addr      = a;
    bus.pm_rd_req = 1'b1;
    bus.pm_addr   = a;
    step();
    bus.rd_en     = 1'b0;
    bus.pm_rd_req = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst             = 1'b1;
    bus.rd_en       = 1'b0;
    bus.addr        = '0;
    bus.pm_addr     = '0;
    bus.pm_wdata    = '0;
    bus.pm_rd_req   = 1'b0;
    bus.unlock_en   = 1'b0;
    bus.unlock_data = 8'h00;
    bus.pm_wr_req   = 1'b0;
    bus.err_clr     = 1'b0;

    // reset
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_instr",    bus.instr,    32'h0);
    check("rst_pm_rdata", bus.pm_rdata, 32'h0);
    check("rst_busy",     bus.busy,     32'h0);
    check("rst_stall",    bus.stall,    32'h0);
    check("rst_done",     bus.done,     32'h0);
    check("rst_wr_err",   bus.wr_err,   32'h0);

    // good write, back-to-back unlock
    seq(8'hAA, 0, 0, 13'h0123, 14'h3FFF);
    check("good_busy_rise", bus.busy, 32'h1);
    wait_write();
    check("good_busy_len",  busy_cycles, 32'd16);
    check("good_done_cnt",  done_cnt,    32'd1);
    check("good_done_last", done_idx,    32'd15);
    read_both(13'h0123);
    check("good_fetch", bus.instr,    32'h3FFF);
    check("good_pmrd",  bus.pm_rdata, 32'h3FFF);
    check("good_err",   bus.wr_err,   32'h0);

    // widest allowed gaps on both sides of 0xAA
    seq(8'hAA, 3, 3, 13'h0000, 14'h1555);
    check("win3_busy", bus.busy, 32'h1);
    wait_write();
    check("win3_busy_len", busy_cycles, 32'd16);
    read_both(13'h0000);
    check("win3_fetch", bus.instr, 32'h1555);

    // bad second unlock byte
    seq(8'hA5, 0, 0, 13'h0123, 14'h0AAA);
    check("bad_busy",   bus.busy,   32'h0);
    check("bad_wr_err", bus.wr_err, 32'h1);
    step();
    check("bad_no_busy_later", bus.busy, 32'h0);
    read_both(13'h0123);
    check("bad_mem_kept", bus.instr, 32'h3FFF);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("err_clr", bus.wr_err, 32'h0);

    // set beats clear in the same cycle
    bus.err_clr   = 1'b1;
    bus.pm_wr_req = 1'b1;
    step();
    bus.err_clr   = 1'b0;
    bus.pm_wr_req = 1'b0;
    check("set_beats_clr", bus.wr_err, 32'h1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("err_clr2", bus.wr_err, 32'h0);

    // unlock window expiry (5 idle cycles)
    seq(8'hAA, 5, 0, 13'h0123, 14'h0001);
    check("exp5_busy", bus.busy,   32'h0);
    check("exp5_err",  bus.wr_err, 32'h1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;

    // unlock window expiry at exactly 4 idle cycles
    seq(8'hAA, 4, 0, 13'h0123, 14'h0002);
    check("exp4_busy", bus.busy,   32'h0);
    check("exp4_err",  bus.wr_err, 32'h1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;

    // armed window expiry at 4 idle cycles after 0xAA
    seq(8'hAA, 0, 4, 13'h0123, 14'h0003);
    check("armexp_busy", bus.busy,   32'h0);
    check("armexp_err",  bus.wr_err, 32'h1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;

    // 3 idle cycles after 0x55 still writes
    seq(8'hAA, 3, 0, 13'h0200, 14'h2222);
    check("win3b_busy", bus.busy, 32'h1);
    wait_write();
    read_both(13'h0200);
    check("win3b_pmrd", bus.pm_rdata, 32'h2222);

    // stall: fetch held, data read and unlock/write strobes during busy
    bus.rd_en = 1'b1;
    bus.addr  = 13'h0123;
    step();
    check("stall_pre_instr", bus.instr, 32'h3FFF);
    seq(8'hAA, 0, 0, 13'h0123, 14'h0ABC);
    check("stall_busy", bus.busy,  32'h1);
    check("stall_flag", bus.stall, 32'h1);
    bus.pm_rd_req = 1'b1;
    bus.pm_addr   = 13'h0000;
    busy_cycles = 0;
    instr_moved = 0;
    rdata_moved = 0;
    err_seen    = 0;
    for (int i = 0; i < 40 && bus.stall === 1'b1; i++) begin
      if (bus.instr !== 14'h3FFF) instr_moved++;
      if (bus.pm_rdata !== 14'h2222) rdata_moved++;
      if (bus.wr_err !== 1'b0) err_seen++;
      busy_cycles++;
      bus.unlock_en   = (i == 3);
      bus.unlock_data = (i == 3) ? 8'h55 : 8'h00;
      bus.pm_wr_req   = (i == 5);
      step();
    end
    bus.unlock_en = 1'b0;
    bus.pm_wr_req = 1'b0;
    check("stall_len",         busy_cycles, 32'd16);
    check("stall_instr_moved", instr_moved, 32'd0);
    check("stall_rdata_moved", rdata_moved, 32'd0);
    check("stall_err_seen",    err_seen,    32'd0);
    check("stall_wr_err",      bus.wr_err,  32'h0);
    check("stall_instr_held",  bus.instr,   32'h3FFF);
    check("stall_rdata_held",  bus.pm_rdata, 32'h2222);
    bus.pm_rd_req = 1'b0;
    step();
    check("post_write_fetch", bus.instr, 32'h0ABC);
    bus.rd_en = 1'b0;

    // the 0x55 strobed during the write must not have been queued
    unlock(8'hAA);
    wr_req(13'h0123, 14'h0777);
    check("noqueue_busy", bus.busy,   32'h0);
    check("noqueue_err",  bus.wr_err, 32'h1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;

    // reset in the middle of a write
    seq(8'hAA, 0, 0, 13'h0200, 14'h3333);
    check("abort_busy", bus.busy, 32'h1);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) done_cnt++;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy_fall", bus.busy,  32'h0);
    check("abort_done",      bus.done,  32'h0);
    check("abort_instr_rst", bus.instr, 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1) done_cnt++;
      step();
    end
    check("abort_no_done", done_cnt, 32'd0);
    read_both(13'h0200);
    check("abort_mem_kept",  bus.instr,    32'h2222);
    check("abort_pmrd_kept", bus.pm_rdata, 32'h2222);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
